// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational 8-bit alu between two requesters.
// Build option ALU_ARB_DIVZERO_EN: divide/modulo by zero returns 8'hFF with rsp_err=1.

module alu (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] x,
  output logic [7:0] op
);
  always_comb begin
    op = 8'h00;
    case (x)
      4'b0000: op = a + b;
      4'b0001: op = a - b;
      4'b0010: op = a * b;
      4'b0011: op = a / b;
      4'b0100: op = a % b;
      4'b0101: op = a & b;
      4'b0110: op = a | b;
      4'b0111: op = {7'd0, (a != 8'h00) && (b != 8'h00)};
      4'b1000: op = {7'd0, (a != 8'h00) || (b != 8'h00)};
      4'b1001: op = a ^ b;
      4'b1010: op = ~a;
      4'b1011: op = {7'd0, a == 8'h00};
      4'b1100: op = {1'b0, a[7:1]};
      4'b1101: op = {a[6:0], 1'b0};
      4'b1110: op = a + 8'd1;
      default: op = a - 8'd1;
    endcase
  end
endmodule

// state | meaning
// IDLE  | waiting for a request; grant is combinational, ready only here
// EXEC  | alu sees latched operands; result and error are registered
// RESP  | response held on the owner's channel until it is consumed
module alu_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req1_valid,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [3:0] req0_x,
  input  logic [3:0] req1_x,
  output logic       rsp0_valid,
  output logic       rsp1_valid,
  input  logic       rsp0_ready,
  input  logic       rsp1_ready,
  output logic [7:0] rsp0_op,
  output logic [7:0] rsp1_op,
  output logic       rsp0_err,
  output logic       rsp1_err
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t     state, state_nxt;
  logic       rst_meta, rst_sync_n;
  logic       prio, owner, grant;
  logic       accept, rsp_hs, div_zero;
  logic [7:0] opa, opb, alu_op, exec_op, rsp_op_r;
  logic [3:0] opx;
`ifdef ALU_ARB_DIVZERO_EN
  logic       rsp_err_r;
`endif

  // Assertion is immediate; release waits two edges so no flop leaves reset near an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  alu u_alu (
    .a  (opa),
    .b  (opb),
    .x  (opx),
    .op (alu_op)
  );

  assign grant    = (req0_valid && req1_valid) ? prio : req1_valid;
  assign accept   = (state == IDLE) && rst_sync_n && (req0_valid || req1_valid);
  assign rsp_hs   = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);
  assign div_zero = ((opx == 4'b0011) || (opx == 4'b0100)) && (opb == 8'h00);

`ifdef ALU_ARB_DIVZERO_EN
  assign exec_op = div_zero ? 8'hFF : alu_op;
`else
  assign exec_op = div_zero ? 8'h00 : alu_op;
`endif

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp0_op    = 8'h00;
    rsp1_op    = 8'h00;
    rsp0_err   = 1'b0;
    rsp1_err   = 1'b0;
    if (state == RESP) begin
      if (owner) begin
        rsp1_valid = 1'b1;
        rsp1_op    = rsp_op_r;
`ifdef ALU_ARB_DIVZERO_EN
        rsp1_err   = rsp_err_r;
`endif
      end else begin
        rsp0_valid = 1'b1;
        rsp0_op    = rsp_op_r;
`ifdef ALU_ARB_DIVZERO_EN
        rsp0_err   = rsp_err_r;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      opa      <= 8'h00;
      opb      <= 8'h00;
      opx      <= 4'h0;
      owner    <= 1'b0;
      prio     <= 1'b0;
      rsp_op_r <= 8'h00;
`ifdef ALU_ARB_DIVZERO_EN
      rsp_err_r <= 1'b0;
`endif
    end else begin
      if (accept) begin
        owner <= grant;
        opa   <= grant ? req1_a : req0_a;
        opb   <= grant ? req1_b : req0_b;
        opx   <= grant ? req1_x : req0_x;
      end
      if (state == EXEC) begin
        rsp_op_r <= exec_op;
`ifdef ALU_ARB_DIVZERO_EN
        rsp_err_r <= div_zero;
`endif
      end
      if (rsp_hs) prio <= ~owner;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level model checked every cycle plus directed literals.
// Honours ALU_ARB_DIVZERO_EN the same way the design does.
`timescale 1ns/1ps
module tb_alu_arbiter;
  logic       clk, rst_n;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] req0_x, req1_x;
  logic       rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [7:0] rsp0_op, rsp1_op;
  logic       rsp0_err, rsp1_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rel = 0;

`ifdef ALU_ARB_DIVZERO_EN
  localparam int DZ_OP = 255;
  localparam int DZ_ERR = 1;
`else
  localparam int DZ_OP = 0;
  localparam int DZ_ERR = 0;
`endif

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_x(req0_x), .req1_x(req1_x),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp0_op(rsp0_op), .rsp1_op(rsp1_op),
    .rsp0_err(rsp0_err), .rsp1_err(rsp1_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Edges seen since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rel <= 0;
    else if (rel < 3) rel <= rel + 1;
  end

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int alu_ref(input int x, input int a, input int b);
    case (x)
      0:  return (a + b) % 256;
      1:  return (a - b + 256) % 256;
      2:  return (a * b) % 256;
      3:  return (b == 0) ? DZ_OP : a / b;
      4:  return (b == 0) ? DZ_OP : a % b;
      5:  return a & b;
      6:  return a | b;
      7:  return (a != 0 && b != 0) ? 1 : 0;
      8:  return (a != 0 || b != 0) ? 1 : 0;
      9:  return a ^ b;
      10: return 255 - a;
      11: return (a == 0) ? 1 : 0;
      12: return a / 2;
      13: return (a * 2) % 256;
      14: return (a + 1) % 256;
      default: return (a + 255) % 256;
    endcase
  endfunction

  // Transaction model: busy from accept until the response is consumed.
  int m_busy = 0, m_prio = 0, m_owner = 0, m_acc = 0, m_op = 0, m_err = 0;

  always @(negedge clk) begin
    int eg0, eg1, ev, ev0, ev1, rdy;
    if (!rst_n) begin
      m_busy = 0;
      m_prio = 0;
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      check("rst_valid0", rsp0_valid, 0);
      check("rst_valid1", rsp1_valid, 0);
      check("rst_op0", rsp0_op, 0);
      check("rst_op1", rsp1_op, 0);
      check("rst_err", {rsp0_err, rsp1_err}, 0);
    end else begin
      eg0 = (m_busy == 0 && rel >= 2 && req0_valid && (!req1_valid || m_prio == 0)) ? 1 : 0;
      eg1 = (m_busy == 0 && rel >= 2 && req1_valid && (!req0_valid || m_prio == 1)) ? 1 : 0;
      ev  = (m_busy == 1 && cyc >= m_acc + 2) ? 1 : 0;
      ev0 = (ev == 1 && m_owner == 0) ? 1 : 0;
      ev1 = (ev == 1 && m_owner == 1) ? 1 : 0;
      check("m_ready0", req0_ready, eg0);
      check("m_ready1", req1_ready, eg1);
      check("m_valid0", rsp0_valid, ev0);
      check("m_valid1", rsp1_valid, ev1);
      check("m_op0", rsp0_op, ev0 ? m_op : 0);
      check("m_op1", rsp1_op, ev1 ? m_op : 0);
      check("m_err0", rsp0_err, ev0 ? m_err : 0);
      check("m_err1", rsp1_err, ev1 ? m_err : 0);
      if (eg0 == 1 || eg1 == 1) begin
        m_busy  = 1;
        m_owner = eg1;
        m_acc   = cyc;
        if (eg1 == 1) begin
          m_op  = alu_ref(req1_x, req1_a, req1_b);
          m_err = (DZ_ERR == 1 && (req1_x == 3 || req1_x == 4) && req1_b == 0) ? 1 : 0;
        end else begin
          m_op  = alu_ref(req0_x, req0_a, req0_b);
          m_err = (DZ_ERR == 1 && (req0_x == 3 || req0_x == 4) && req0_b == 0) ? 1 : 0;
        end
      end else if (ev == 1) begin
        rdy = m_owner ? rsp1_ready : rsp0_ready;
        if (rdy == 1) begin
          m_busy = 0;
          m_prio = 1 - m_owner;
        end
      end
    end
  end

  task automatic set_req(input int n, input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] x);
    if (n == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_x = x;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_x = x;
    end
  endtask

  task automatic issue(input int n, input logic [7:0] a, input logic [7:0] b, input logic [3:0] x,
                       input int eop, input int eerr, input string nm);
    int k, t0;
    set_req(n, 1'b1, a, b, x);
    k = 0;
    do begin @(negedge clk); k++; end
    while (!(n == 0 ? req0_ready : req1_ready) && k < 30);
    check({nm, "_accept"}, n == 0 ? req0_ready : req1_ready, 1);
    t0 = cyc;
    @(posedge clk); #1;
    set_req(n, 1'b0, a, b, x);
    k = 0;
    do begin @(negedge clk); k++; end
    while (!(n == 0 ? rsp0_valid : rsp1_valid) && k < 30);
    check({nm, "_latency"}, cyc - t0, 2);
    check({nm, "_op"}, n == 0 ? rsp0_op : rsp1_op, eop);
    check({nm, "_err"}, n == 0 ? rsp0_err : rsp1_err, eerr);
    @(posedge clk); #1;
  endtask

  initial begin
    int k, grants;
    rst_n = 1'b0;
    set_req(0, 1'b0, 8'h00, 8'h00, 4'h0);
    set_req(1, 1'b0, 8'h00, 8'h00, 4'h0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Contention: strict alternation starting with requester 0.
    set_req(0, 1'b1, 8'h10, 8'h10, 4'b0010);
    set_req(1, 1'b1, 8'h00, 8'h01, 4'b0001);
    grants = 0;
    k = 0;
    while (grants < 4 && k < 60) begin
      @(negedge clk); k++;
      if (rsp0_valid) check("cont_op0", rsp0_op, 8'h00);
      if (rsp1_valid) check("cont_op1", rsp1_op, 8'hFF);
      if (req0_ready || req1_ready) begin
        check("cont_order", req1_ready, grants % 2);
        grants++;
      end
    end
    check("cont_grants", grants, 4);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp1_valid) check("cont_op1_last", rsp1_op, 8'hFF);
    end
    @(posedge clk); #1;

    issue(0, 8'h0F, 8'h01, 4'b0000, 8'h10, 0, "single_add");

    // Backpressure on requester 1 while requester 0 waits.
    rsp1_ready = 1'b0;
    set_req(1, 1'b1, 8'hFF, 8'h00, 4'b1110);
    k = 0;
    do begin @(negedge clk); k++; end while (!req1_ready && k < 30);
    check("bp_accept", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    set_req(0, 1'b1, 8'h01, 8'h01, 4'b0000);
    k = 0;
    do begin @(negedge clk); k++; end while (!rsp1_valid && k < 30);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_valid", rsp1_valid, 1);
      check("bp_op", rsp1_op, 8'h00);
      check("bp_req0_ready", req0_ready, 0);
    end
    @(posedge clk); #1;
    rsp1_ready = 1'b1;
    issue(0, 8'h01, 8'h01, 4'b0000, 8'h02, 0, "bp_next");

    issue(0, 8'h20, 8'h00, 4'b0011, DZ_OP, DZ_ERR, "div_zero");
    issue(0, 8'h07, 8'h03, 4'b0100, 8'h01, 0, "mod");
    issue(1, 8'h05, 8'h00, 4'b0111, 8'h00, 0, "land");
    issue(1, 8'h00, 8'h00, 4'b1011, 8'h01, 0, "lnot");
    issue(0, 8'h81, 8'h00, 4'b1101, 8'h02, 0, "shl");

    // Reset during EXEC; requester 1 would win on priority beforehand.
    set_req(0, 1'b1, 8'h03, 8'h04, 4'b0010);
    set_req(1, 1'b1, 8'h05, 8'h06, 4'b0000);
    k = 0;
    do begin @(negedge clk); k++; end while (!(req0_ready || req1_ready) && k < 30);
    check("pre_rst_grant1", req1_ready, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_imm_ready", {req0_ready, req1_ready}, 0);
    check("rst_imm_valid", {rsp0_valid, rsp1_valid}, 0);
    check("rst_imm_op", {rsp0_op, rsp1_op}, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    k = 0;
    do begin
      @(negedge clk); k++;
      check("post_rst_no_rsp", {rsp0_valid, rsp1_valid}, 0);
    end while (!(req0_ready || req1_ready) && k < 30);
    check("post_rst_wait", k, 3);
    check("post_rst_grant0", req0_ready, 1);
    check("post_rst_grant1", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!rsp0_valid && k < 30);
    check("post_rst_op", rsp0_op, 8'h0C);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
